// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam logic MODE_ALIGNED = 1'b0;
  localparam logic MODE_STAGGER = 1'b1;

  // Phase offset of channel k when the channels are spread evenly over one period.
  function automatic int unsigned stagger_offset(input int unsigned k,
                                                 input int unsigned width,
                                                 input int unsigned channels);
    return (k << width) / channels;
  endfunction

  function automatic int unsigned sat_step(input int unsigned duty,
                                           input int unsigned step,
                                           input int unsigned max_duty,
                                           input logic        up);
    int unsigned r;
    if (up) r = ((duty + step) > max_duty) ? max_duty : duty + step;
    else    r = (duty < step) ? 0 : duty - step;
    return r;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw button to single-cycle press pulse: 2-flop synchronizer, counting debouncer, rising-edge detect.
module button_debounce #(
  parameter int DEBOUNCE = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb;
  logic          r_deb_d;
  logic          r_armed;
  logic [1:0]    r_fill;
  logic [CW-1:0] r_dcnt;

  // A press is only honoured once the button has been seen released after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_armed <= 1'b0;
      r_fill  <= '0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      r_deb_d <= r_deb;
      if (r_fill[1] && !r_sync2) r_armed <= 1'b1;
      if (r_sync2 != r_deb) begin
        if (r_dcnt == CW'(DEBOUNCE - 1)) begin
          r_deb  <= ~r_deb;
          r_dcnt <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end else begin
        r_dcnt <= '0;
      end
    end
  end

  assign o_press = r_deb & ~r_deb_d & r_armed;

endmodule

// File: rtl/pwm_multi.sv
// CHANNELS PWM outputs from one shared period counter; button-stepped duties shadowed to the period wrap.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int STEP     = 1,
  parameter int DEBOUNCE = 2
) (
  input  logic                                             i_clk,
  input  logic                                             i_rst_n,
  input  logic                                             i_increase_duty,
  input  logic                                             i_decrease_duty,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] i_sel,
  input  logic                                             i_mode,
  output logic [CHANNELS-1:0]                              o_pwm,
  output logic [WIDTH:0]                                   o_duty
);

  localparam int          DW   = WIDTH + 1;
  localparam int          SW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned FULL = 1 << WIDTH;

  logic                w_inc;
  logic                w_dec;
  logic                w_wrap;
  logic [WIDTH-1:0]    r_cnt;
  logic                r_mode_a;
  logic [DW-1:0]       r_duty_p [CHANNELS];
  logic [DW-1:0]       r_duty_a [CHANNELS];
  logic [WIDTH-1:0]    w_ph     [CHANNELS];
  logic [CHANNELS-1:0] w_hi;
  logic [CHANNELS-1:0] r_pwm;

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_increase_duty),
    .o_press (w_inc)
  );

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_dec (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_decrease_duty),
    .o_press (w_dec)
  );

  assign w_wrap = &r_cnt;

  // Period counter; the active duties and mode are reloaded only on the wrap edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_mode_a <= MODE_ALIGNED;
      r_duty_a <= '{default: '0};
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_wrap) begin
        r_duty_a <= r_duty_p;
        r_mode_a <= i_mode;
      end
    end
  end

  // Simultaneous increase and decrease presses cancel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty_p <= '{default: '0};
    end else if (w_inc ^ w_dec) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (i_sel == SW'(k))
          r_duty_p[k] <= DW'(sat_step(32'(r_duty_p[k]), STEP, FULL, w_inc));
      end
    end
  end

  always_comb begin
    w_hi = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_ph[k] = r_cnt;
      if (r_mode_a == MODE_STAGGER)
        w_ph[k] = r_cnt + WIDTH'(stagger_offset(k, WIDTH, CHANNELS));
      w_hi[k] = ({1'b0, w_ph[k]} < r_duty_a[k]);
    end
  end

  // Registered compare: outputs lag the counter by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pwm <= '0;
    else          r_pwm <= w_hi;
  end

  assign o_pwm  = r_pwm;
  assign o_duty = r_duty_p[i_sel];

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with WIDTH=4, CHANNELS=4, STEP=1, DEBOUNCE=2.
module tb_pwm_multi;

  localparam int W  = 4;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inc;
  logic          dec;
  logic [1:0]    sel;
  logic          mode;
  logic [CH-1:0] pwm;
  logic [W:0]    duty;

  logic [3:0]    tb_cnt;
  logic [15:0]   pat [CH];
  int            n_checks = 0;
  int            n_fail   = 0;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .STEP(1), .DEBOUNCE(2)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_increase_duty (inc),
    .i_decrease_duty (dec),
    .i_sel           (sel),
    .i_mode          (mode),
    .o_pwm           (pwm),
    .o_duty          (duty)
  );

  always #5 clk = ~clk;

  // Reference period counter value, as it stands after each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic press(input logic up, input logic dn, input int hold);
    inc = up;
    dec = dn;
    repeat (hold) @(negedge clk);
    inc = 1'b0;
    dec = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic settle();
    repeat (16) @(negedge clk);
  endtask

  // Captures one full period: sample j reflects the compare made at cnt == j.
  task automatic measure();
    while (tb_cnt != 4'd1) @(negedge clk);
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < CH; k++) pat[k][j] = pwm[k];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inc = 1'b0; dec = 1'b0; sel = 2'd0; mode = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (pwm !== 4'b0000) begin n_fail++; $display("FAIL reset_pwm: got %b want 0000", pwm); end
    n_checks++;
    if (duty !== 5'd0) begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty); end
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm !== 4'b0000) begin n_fail++; $display("FAIL post_reset_pwm cycle %0d: got %b want 0000", i, pwm); end
    end
  endtask

  task automatic test_reset_mid_press();
    sel = 2'd0;
    inc = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (duty !== 5'd1) begin n_fail++; $display("FAIL pre_reset_press: got %0d want 1", duty); end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (duty !== 5'd0) begin n_fail++; $display("FAIL held_through_reset: got %0d want 0", duty); end
    inc = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (duty !== 5'd0) begin n_fail++; $display("FAIL release_after_reset: got %0d want 0", duty); end
    press(1'b1, 1'b0, 6);
    n_checks++;
    if (duty !== 5'd1) begin n_fail++; $display("FAIL repress_after_reset: got %0d want 1", duty); end
    press(1'b0, 1'b1, 6);
    n_checks++;
    if (duty !== 5'd0) begin n_fail++; $display("FAIL decrease_basic: got %0d want 0", duty); end
  endtask

  task automatic test_single_press();
    sel = 2'd1;
    for (int p = 0; p < 3; p++) begin
      inc = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (duty !== 5'(p)) begin n_fail++; $display("FAIL press%0d_early: got %0d want %0d", p, duty, p); end
      @(negedge clk);
      n_checks++;
      if (duty !== 5'(p + 1)) begin n_fail++; $display("FAIL press%0d_latency: got %0d want %0d", p, duty, p + 1); end
      @(negedge clk);
      inc = 1'b0;
      repeat (8) @(negedge clk);
    end
    n_checks++;
    if (duty !== 5'd3) begin n_fail++; $display("FAIL single_press_total: got %0d want 3", duty); end
    sel = 2'd0;
    #1;
    n_checks++;
    if (duty !== 5'd0) begin n_fail++; $display("FAIL unselected_ch0: got %0d want 0", duty); end
    settle();
    measure();
    for (int k = 0; k < CH; k++) begin
      n_checks++;
      if ($countones(pat[k]) != ((k == 1) ? 3 : 0)) begin
        n_fail++;
        $display("FAIL single_press_highs ch%0d: got %0d want %0d", k, $countones(pat[k]), (k == 1) ? 3 : 0);
      end
    end
    n_checks++;
    if (pat[1] !== 16'h0007) begin n_fail++; $display("FAIL single_press_shape: got %h want 0007", pat[1]); end
  endtask

  task automatic test_bounce();
    sel = 2'd1;
    for (int i = 0; i < 10; i++) begin
      inc = (i % 2 == 0);
      @(negedge clk);
    end
    inc = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (duty !== 5'd3) begin n_fail++; $display("FAIL bounce_rejected: got %0d want 3", duty); end
    press(1'b1, 1'b0, 6);
    n_checks++;
    if (duty !== 5'd4) begin n_fail++; $display("FAIL bounce_then_hold: got %0d want 4", duty); end
  endtask

  task automatic test_saturation();
    sel = 2'd0;
    repeat (17) press(1'b1, 1'b0, 6);
    n_checks++;
    if (duty !== 5'd16) begin n_fail++; $display("FAIL sat_high: got %0d want 16", duty); end
    settle();
    measure();
    n_checks++;
    if (pat[0] !== 16'hFFFF) begin n_fail++; $display("FAIL full_duty_high: got %h want ffff", pat[0]); end
    press(1'b1, 1'b0, 6);
    n_checks++;
    if (duty !== 5'd16) begin n_fail++; $display("FAIL sat_high_extra: got %0d want 16", duty); end
    repeat (17) press(1'b0, 1'b1, 6);
    n_checks++;
    if (duty !== 5'd0) begin n_fail++; $display("FAIL sat_low: got %0d want 0", duty); end
    settle();
    measure();
    n_checks++;
    if (pat[0] !== 16'h0000) begin n_fail++; $display("FAIL zero_duty_low: got %h want 0000", pat[0]); end
    press(1'b0, 1'b1, 6);
    n_checks++;
    if (duty !== 5'd0) begin n_fail++; $display("FAIL sat_low_extra: got %0d want 0", duty); end
    sel = 2'd1;
    #1;
    n_checks++;
    if (duty !== 5'd4) begin n_fail++; $display("FAIL sat_other_ch: got %0d want 4", duty); end
  endtask

  task automatic test_shadow();
    sel = 2'd2;
    settle();
    while (tb_cnt != 4'd0) @(negedge clk);
    fork
      measure();
      begin
        while (tb_cnt != 4'd2) @(negedge clk);
        inc = 1'b1;
        repeat (6) @(negedge clk);
        inc = 1'b0;
      end
    join
    n_checks++;
    if ($countones(pat[2]) != 0) begin n_fail++; $display("FAIL shadow_mid_period: got %0d highs want 0", $countones(pat[2])); end
    n_checks++;
    if (duty !== 5'd1) begin n_fail++; $display("FAIL shadow_pending: got %0d want 1", duty); end
    measure();
    n_checks++;
    if ($countones(pat[2]) != 1) begin n_fail++; $display("FAIL shadow_next_period: got %0d highs want 1", $countones(pat[2])); end
    // Press timed to land on the wrap edge itself.
    while (tb_cnt != 4'd11) @(negedge clk);
    inc = 1'b1;
    measure();
    n_checks++;
    if ($countones(pat[2]) != 1) begin n_fail++; $display("FAIL boundary_press_same: got %0d highs want 1", $countones(pat[2])); end
    measure();
    n_checks++;
    if ($countones(pat[2]) != 2) begin n_fail++; $display("FAIL boundary_press_next: got %0d highs want 2", $countones(pat[2])); end
    inc = 1'b0;
    repeat (8) @(negedge clk);
    press(1'b1, 1'b1, 6);
    n_checks++;
    if (duty !== 5'd2) begin n_fail++; $display("FAIL simultaneous_press: got %0d want 2", duty); end
  endtask

  task automatic test_stagger();
    logic exp_bit;
    int   on;
    sel = 2'd0; repeat (4) press(1'b1, 1'b0, 6);
    sel = 2'd2; repeat (2) press(1'b1, 1'b0, 6);
    sel = 2'd3; repeat (4) press(1'b1, 1'b0, 6);
    for (int k = 0; k < CH; k++) begin
      sel = 2'(k);
      #1;
      n_checks++;
      if (duty !== 5'd4) begin n_fail++; $display("FAIL stagger_setup ch%0d: got %0d want 4", k, duty); end
    end
    settle();
    while (tb_cnt != 4'd6) @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
    while (tb_cnt != 4'd1) begin
      n_checks++;
      if (pwm !== 4'b0000) begin n_fail++; $display("FAIL mode_mid_period cnt %0d: got %b want 0000", tb_cnt, pwm); end
      @(negedge clk);
    end
    measure();
    for (int k = 0; k < CH; k++) begin
      for (int j = 0; j < 16; j++) begin
        exp_bit = (((j + 4 * k) % 16) < 4);
        n_checks++;
        if (pat[k][j] !== exp_bit) begin
          n_fail++;
          $display("FAIL stagger ch%0d cnt%0d: got %b want %b", k, j, pat[k][j], exp_bit);
        end
      end
    end
    for (int j = 0; j < 16; j++) begin
      on = 0;
      for (int k = 0; k < CH; k++) on += int'(pat[k][j]);
      n_checks++;
      if (on != 1) begin n_fail++; $display("FAIL stagger_overlap cnt%0d: got %0d channels high want 1", j, on); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_press();
    test_single_press();
    test_bounce();
    test_saturation();
    test_shadow();
    test_stagger();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel successor to the single-output `pwm` block: `CHANNELS` independent PWM outputs driven from one shared `WIDTH`-bit period counter. Each channel has its own duty register, stepped by debounced increase/decrease buttons, with a channel-select input choosing which channel the buttons act on. Duty updates are shadowed to the period boundary, which keeps every output glitch-free. An optional staggered mode phase-shifts the channels evenly across the period. The block sits directly behind the chip I/O in the same TinyTapeout-style top.

## Interface
- `WIDTH`, 8: period counter width; period = 2^WIDTH cycles.
- `CHANNELS`, 4: number of PWM outputs; power of 2, 1..2^WIDTH.
- `STEP`, 1: duty increment/decrement per accepted press.
- `DEBOUNCE`, 2: consecutive cycles a synchronized button level must differ before it is accepted (≥1).

Ports:
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_increase_duty`  in  1  raw button, asynchronous.
- `i_decrease_duty`  in  1  raw button, asynchronous.
- `i_sel`  in  max(1,$clog2(CHANNELS))  channel the buttons act on; must be stable while a press is accepted.
- `i_mode`  in  1  0 = aligned, 1 = staggered.
- `o_pwm`  out  CHANNELS  PWM outputs.
- `o_duty`  out  WIDTH+1  pending duty register of the channel selected by `i_sel` (combinational readback).

## Operation
- Button path, per button: 2-flop synchronizer, then debouncer, then rising-edge detect.
  - Debounced level `deb` toggles on the DEBOUNCE-th consecutive edge at which the synchronized level ≠ `deb`.
  - Any cycle with equality clears the debounce count.
  - A press is one 0→1 transition of `deb`; holding the button produces no repeats.
- Pending duty `duty_p[k]`, WIDTH+1 bits, range 0..2^WIDTH.
  - Increase press: `duty_p[sel] = min(duty_p[sel]+STEP, 2^WIDTH)`.
  - Decrease press: `duty_p[sel] = max(duty_p[sel]-STEP, 0)`.
  - Arithmetic is done in WIDTH+2 bits; the result saturates and never wraps.
  - Increase and decrease press in the same cycle: no change.
  - Unselected channels never change.
- Period counter `cnt`, WIDTH bits, free-running 0..2^WIDTH-1, wraps to 0.
- Period boundary is the edge where `cnt` wraps to 0. At that edge:
  - `duty_a[k] <= duty_p[k]` for all k.
  - `mode_a <= i_mode`.
  - A press accepted on the boundary edge itself lands in `duty_p` and takes effect at the next boundary.
- Output generation:
  - Phase `ph[k]` = `cnt` in aligned mode; `(cnt + k*2^WIDTH/CHANNELS) mod 2^WIDTH` in staggered mode.
  - `o_pwm[k] = (ph[k] < duty_a[k])`, registered.
  - Duty 0 gives constant low; duty 2^WIDTH gives constant high.
  - Otherwise each period has exactly `duty_a[k]` high cycles.
- Reset (async assert, sync-style deassert acceptable):
  - `cnt`, all `duty_p`, `duty_a`, `mode_a`, synchronizers, debouncers and edge detectors clear to 0.
  - `o_pwm` = 0, `o_duty` = 0.
  - Reset mid-press discards the press; the button must be seen released→pressed again after reset.

## Timing
- Button: a level change sampled first at edge N makes `deb` toggle at edge N+1+DEBOUNCE. `duty_p` (and `o_duty`) updates at edge N+2+DEBOUNCE.
- Duty to output: a new `duty_p` affects `o_pwm` from the first period starting after it is written. `o_pwm` lags `cnt` by one cycle (registered compare).
- Mode change: applied only at a period boundary; a mid-period change has no effect until the wrap.
- `o_duty` follows `i_sel` combinationally, with 0 cycles of latency.

## Structure
- Package `pwm_pkg`:
  - mode constants `MODE_ALIGNED`=0, `MODE_STAGGER`=1.
  - function computing the stagger offset `k*2^WIDTH/CHANNELS`.
  - saturating add/sub function.
- Sub-module `button_debounce` (synchronizer + debouncer + rising-edge pulse, parameter DEBOUNCE), instantiated twice.
- Top contains the counter, duty arrays, shadow-load logic and compare/output registers.

## Test plan
Parameters for all scenarios: WIDTH=4, CHANNELS=4, STEP=1, DEBOUNCE=2.
- Reset: hold `i_rst_n`=0 for 5 cycles -> `o_pwm`=0000 and `o_duty`=0; after release, `o_pwm` stays 0000 for 2 full periods (32 cycles).
- Single press: `i_sel`=1, increase held 6 cycles, 3 times -> `o_duty`=3, each update 4 edges after the first sampling edge; from the next boundary ch1 is high 3 of 16 cycles and other channels stay 0.
- Bounce rejection: increase toggled 1 cycle high / 1 cycle low for 10 cycles, then held -> exactly one increment.
- Saturation: 17 presses on ch0 -> `o_duty`=16 and `o_pwm[0]` constant high; further increase -> unchanged. 17 decrease presses -> 0 and constant low; further decrease -> stays 0.
- Shadowing and simultaneous presses: a press accepted mid-period leaves the high-pulse count unchanged until the wrap. Increase and decrease both held -> no change.
- Stagger: all duties 4, `i_mode`=1 mid-period -> aligned until the wrap, then ch k rises 4k cycles earlier in `cnt` terms (offset 4k). Each channel stays high 4 cycles and the pulses do not overlap.
